load_store_unit: RTL

- Memory-access stage directly upstream of the 16x8 data memory. It accepts load/store requests from the execute stage over a valid/ready handshake and owns the data memory's write-enable, address and data ports.
- Stores are posted into a small in-order store buffer and drained one per cycle.
- Loads are read from memory, or forwarded from the buffer, and returned as a tagged one-cycle writeback pulse.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit_store_buffer.sv | 79 +++++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit slice.
// Widths are package constants so the interface, the store buffer entry
// type and the top all agree without threading parameters through.
package lsu_pkg;

  localparam int ADDR_W = 4;  // 16-word data memory
  localparam int DATA_W = 8;  // data word width
  localparam int TAG_W  = 3;  // destination-register tag width

  // DRAIN is only reachable when store forwarding is compiled out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } lsu_state_t;

  // One posted store waiting to be written to memory.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_entry_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port bundle of the LSU.
// slave  : the load/store unit's view.
// master : the environment's view (execute stage and data memory).
interface load_store_unit_if;
  import lsu_pkg::*;

  // Execute-stage request
  logic              Req_Valid;
  logic              Req_Ready;
  logic              Req_Is_Store;
  logic [ADDR_W-1:0] Req_Address;
  logic [DATA_W-1:0] Req_Data;
  logic [TAG_W-1:0]  Req_Tag;

  // Load writeback pulse
  logic              Resp_Valid;
  logic [DATA_W-1:0] Resp_Data;
  logic [TAG_W-1:0]  Resp_Tag;

  // Data memory ports
  logic              Mem_Busy;
  logic              Mem_Write_Enable;
  logic [ADDR_W-1:0] Mem_Write_Address;
  logic [ADDR_W-1:0] Mem_Read_Address;
  logic [DATA_W-1:0] Mem_Data_In;
  logic [DATA_W-1:0] Mem_Data_Out;

  modport slave (
    input  Req_Valid, Req_Is_Store, Req_Address, Req_Data, Req_Tag,
    input  Mem_Busy, Mem_Data_Out,
    output Req_Ready, Resp_Valid, Resp_Data, Resp_Tag,
    output Mem_Write_Enable, Mem_Write_Address, Mem_Read_Address, Mem_Data_In
  );

  modport master (
    output Req_Valid, Req_Is_Store, Req_Address, Req_Data, Req_Tag,
    output Mem_Busy, Mem_Data_Out,
    input  Req_Ready, Resp_Valid, Resp_Data, Resp_Tag,
    input  Mem_Write_Enable, Mem_Write_Address, Mem_Read_Address, Mem_Data_In
  );

endinterface

// File: rtl/load_store_unit_store_buffer.sv
// In-order circular store buffer for the load/store unit.
// Optional feature macro: LSU_STORE_FWD_EN adds a youngest-match address
// lookup port used for store-to-load forwarding.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2  // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  store_entry_t             push_entry,
  input  logic                     pop,
  output store_entry_t             head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef LSU_STORE_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  store_entry_t      entries [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count_q;

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage, written at the tail on push.
  // NOTE: the entry array is deliberately not reset; count_q alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  assign head_entry = entries[rd_ptr];
  assign count      = count_q;
  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign empty      = (count_q == '0);

`ifdef LSU_STORE_FWD_EN
  // Youngest-match lookup: walk live entries oldest to youngest so the
  // last hit, i.e. the most recent store to the address, wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count_q) &&
          (entries[rd_ptr + PTR_W'(i)].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = entries[rd_ptr + PTR_W'(i)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage in front of the 16x8 data memory.
// Stores are posted to an in-order buffer and drained one per cycle when
// the memory is free; loads return a tagged one-cycle writeback pulse.
// Optional feature macro: LSU_STORE_FWD_EN. When defined, loads snapshot a
// forward result from the store buffer; when undefined, a load first waits
// in DRAIN until all older stores have reached memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 2  // store buffer entries, power of two, >= 2
) (
  input  logic               Clock,
  input  logic               Reset,
  load_store_unit_if.slave   bus,
  output logic               Busy
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  lsu_state_t        state;
  lsu_state_t        next_state;
  logic              resp_fire;

  logic              accept;
  logic              load_accept;
  logic              sb_push;
  logic              sb_pop;
  logic              sb_full;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;
  store_entry_t      sb_head;
  store_entry_t      sb_push_entry;
  logic [TAG_W-1:0]  load_tag;

`ifdef LSU_STORE_FWD_EN
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Handshake: ready only when idle with buffer room, regardless of type.
  assign bus.Req_Ready = (state == IDLE) && !sb_full;
  assign accept        = bus.Req_Valid && bus.Req_Ready;
  assign load_accept   = accept && !bus.Req_Is_Store;
  assign sb_push       = accept && bus.Req_Is_Store;
  assign sb_push_entry = '{addr: bus.Req_Address, data: bus.Req_Data};

  // Drain the head whenever memory is not held by its external owner.
  assign bus.Mem_Write_Enable  = !sb_empty && !bus.Mem_Busy;
  assign bus.Mem_Write_Address = sb_head.addr;
  assign bus.Mem_Data_In       = sb_head.data;
  assign sb_pop                = bus.Mem_Write_Enable;

  assign Busy = !sb_empty || (state != IDLE);

  store_buffer #(
    .DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk         (Clock),
    .rst         (Reset),
    .push        (sb_push),
    .push_entry  (sb_push_entry),
    .pop         (sb_pop),
    .head_entry  (sb_head),
    .full        (sb_full),
    .empty       (sb_empty),
    .count       (sb_count)
`ifdef LSU_STORE_FWD_EN
    ,
    .lookup_addr (bus.Req_Address),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data)
`endif
  );

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state and response-fire decode.
  always_comb begin
    next_state = state;
    resp_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (load_accept) begin
`ifdef LSU_STORE_FWD_EN
          next_state = LOAD;
`else
          next_state = sb_empty ? LOAD : DRAIN;
`endif
        end
      end
      LOAD: begin
        if (!bus.Mem_Busy) begin
          next_state = IDLE;
          resp_fire  = 1'b1;
        end
      end
`ifndef LSU_STORE_FWD_EN
      DRAIN: begin
        // Leave once no older store remains (already empty, or last pop now).
        if (sb_empty || (sb_pop && (sb_count == CNT_W'(1)))) next_state = LOAD;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Load datapath: capture request at accept, produce the writeback pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.Mem_Read_Address <= '0;
      load_tag             <= '0;
      bus.Resp_Valid       <= 1'b0;
      bus.Resp_Data        <= '0;
      bus.Resp_Tag         <= '0;
`ifdef LSU_STORE_FWD_EN
      fwd_hit              <= 1'b0;
      fwd_data             <= '0;
`endif
    end else begin
      bus.Resp_Valid <= resp_fire;
      if (load_accept) begin
        bus.Mem_Read_Address <= bus.Req_Address;
        load_tag             <= bus.Req_Tag;
`ifdef LSU_STORE_FWD_EN
        // Snapshot covers any matching store drained while the load waits.
        fwd_hit              <= lookup_hit;
        fwd_data             <= lookup_data;
`endif
      end
      if (resp_fire) begin
`ifdef LSU_STORE_FWD_EN
        bus.Resp_Data <= fwd_hit ? fwd_data : bus.Mem_Data_Out;
`else
        bus.Resp_Data <= bus.Mem_Data_Out;
`endif
        bus.Resp_Tag  <= load_tag;
      end
    end
  end

endmodule
